// File: rtl/h_bitwise_serial_if.sv
// ---------------------------------------------------------------------------
// h_bitwise_serial_if
//   Handshake/operand bundle for h_bitwise_serial.
//   Signals:
//     in_valid  producer -> engine  operand/op valid
//     in_ready  engine -> producer  engine can accept (IDLE only)
//     op        producer -> engine  3-bit opcode
//     a, b      producer -> engine  WIDTH-bit operands
//     out_valid engine -> consumer  result valid (DONE only)
//     out_ready consumer -> engine  consumer takes result
//     out       engine -> consumer  WIDTH-bit result register
//     busy      engine -> system    high in RUN or DONE
//     zero      engine -> consumer  result-is-zero flag (H_BITWISE_ZERO_FLAG_EN only)
//   Modports: master (producer/consumer side), slave (engine side).
// ---------------------------------------------------------------------------
interface h_bitwise_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;
`ifdef H_BITWISE_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
`ifdef H_BITWISE_ZERO_FLAG_EN
    input  zero,
`endif
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
`ifdef H_BITWISE_ZERO_FLAG_EN
    output zero,
`endif
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/h_bitwise_serial.sv
// ---------------------------------------------------------------------------
// h_bitwise_serial
//   Multi-op bitwise logic engine. Latches two WIDTH-bit operands and an
//   opcode on accept, then produces the result SLICE bits per clock, LSB
//   slice first, into the output register. Valid/ready on both sides.
//
//   Parameters:
//     WIDTH  operand/result width (WIDTH % SLICE must be 0)
//     SLICE  bits computed per RUN cycle
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    h_bitwise_serial_if.slave (in_valid/in_ready/op/a/b,
//            out_valid/out_ready/out, busy[, zero])
//   Optional feature:
//     H_BITWISE_ZERO_FLAG_EN  adds registered bus.zero = (result == 0),
//                             updated on entry to DONE, cleared on accept.
//
//   Opcodes: 000 a&b, 001 a|b, 010 a^b, 011 ~(a&b), 100 ~(a|b),
//            101 ~(a^b), 110 ~a, 111 a&~b
// ---------------------------------------------------------------------------
module h_bitwise_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  h_bitwise_serial_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  generate
    if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
      $error("h_bitwise_serial: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef H_BITWISE_ZERO_FLAG_EN
  logic             r_zero;
`endif

  int unsigned      w_base;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_res_sl;
  logic [WIDTH-1:0] w_out_next;

  // Slice datapath: select the current slice of each operand, apply the
  // latched opcode, and merge it into the result register image.
  always_comb begin
    w_base   = 32'(r_cnt) * SLICE;
    w_a_sl   = r_a[w_base +: SLICE];
    w_b_sl   = r_b[w_base +: SLICE];
    w_res_sl = '0;
    unique case (r_op)
      OP_AND:  w_res_sl = w_a_sl & w_b_sl;
      OP_OR:   w_res_sl = w_a_sl | w_b_sl;
      OP_XOR:  w_res_sl = w_a_sl ^ w_b_sl;
      OP_NAND: w_res_sl = ~(w_a_sl & w_b_sl);
      OP_NOR:  w_res_sl = ~(w_a_sl | w_b_sl);
      OP_XNOR: w_res_sl = ~(w_a_sl ^ w_b_sl);
      OP_NOTA: w_res_sl = ~w_a_sl;
      OP_ANDN: w_res_sl = w_a_sl & ~w_b_sl;
      default: w_res_sl = '0;
    endcase
    w_out_next                   = r_out;
    w_out_next[w_base +: SLICE]  = w_res_sl;
  end

  // Control FSM with registered handshake outputs. The handshake flags are
  // updated on the same edges as the state so they always mirror it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_AND;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef H_BITWISE_ZERO_FLAG_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op       <= op_e'(bus.op);
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_out      <= '0;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef H_BITWISE_ZERO_FLAG_EN
            r_zero     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          r_out <= w_out_next;
          if (r_cnt == LAST_CNT) begin
            r_cnt       <= '0;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
`ifdef H_BITWISE_ZERO_FLAG_EN
            r_zero      <= (w_out_next == '0);
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // in_valid is deliberately not looked at here: the next accept
          // can only happen from IDLE, one edge after the result handshake.
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.busy      = r_busy;
`ifdef H_BITWISE_ZERO_FLAG_EN
  assign bus.zero      = r_zero;
`endif

endmodule
